keypad_scan_ctrl: RTL and testbench
===================================

Name: keypad_scan_ctrl

Overview:
- Upstream input stage of the 4-bit CPU.
- Scans a 4x4 matrix keypad, synchronises and debounces the row lines, and encodes the pressed key.
- Feeds the CPU's key_value[3:0] and key_valid inputs; INREG and KEYCHREG sample these every clock.
- key_valid is therefore a debounced level that stays high for the whole press, not a one-cycle pulse.

Parameters:
- SCAN_DIV, 131072: clk cycles per scan tick; one column is driven per tick.
- DEB_N, 8: consecutive stable ticks required for both press and release debounce; legal range 2..255.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset_p  in  1  asynchronous, active-low reset.
- row  in  4  keypad row lines; active-high, pulled down externally, asynchronous to clk.
- col  out  4  one-hot column drive, active-high.
- key_value  out  4  encoded key, row_idx*4 + col_idx.
- key_valid  out  1  high while a debounced key is held.

Behaviour:
- Reset (reset_p=0, asynchronous):
  - col=4'b0001, key_value=4'h0, key_valid=0.
  - State=SCAN; tick counter, debounce counter and synchroniser cleared.
  - A reset during DEBOUNCE or PRESSED abandons the key with no output glitch beyond the reset values.
- Synchroniser: row passes through 2 flops to give row_s. This adds 2 cycles of latency; no other logic uses raw row.
- Tick generator:
  - Free-running counter 0..SCAN_DIV-1.
  - tick is 1 for one clk when the counter equals SCAN_DIV-1, then the counter wraps to 0.
  - All FSM decisions occur only on tick cycles.
- FSM states: SCAN, DEBOUNCE, PRESSED.
- SCAN, on tick:
  - If row_s != 0: latch col_idx from col and row_idx = lowest set bit of row_s; latch raw row_s as row_ref; deb_cnt=1; go to DEBOUNCE; col is held.
  - Else: rotate col left (0001→0010→0100→1000→0001).
- DEBOUNCE, on tick:
  - If row_s == row_ref: deb_cnt++.
  - When deb_cnt reaches DEB_N on that edge: key_value={row_idx,col_idx} (as row_idx*4+col_idx), key_valid=1, deb_cnt=0, go to PRESSED.
  - If row_s != row_ref (bounce, release, or second key): return to SCAN and rotate col. key_value and key_valid are unchanged.
- PRESSED, on tick:
  - col is held.
  - If row_s == 0: deb_cnt++; else deb_cnt=0.
  - When deb_cnt reaches DEB_N: key_valid=0, go to SCAN, rotate col.
  - key_value holds its last value after release.
- Multiple keys:
  - Same column: lowest row index wins.
  - Keys in other columns are invisible while col is held.
  - A change of row pattern in PRESSED that stays non-zero keeps the key held, with key_value unchanged.
- Press latency: key_valid rises on the tick DEB_N-1 ticks after the detecting tick. Release latency is DEB_N ticks of row_s==0.
- key_value changes only on the edge where key_valid rises, so the CPU never sees key_value change while key_valid=1.
- Outputs are registered; there is no combinational path from row.

Decomposition:
- Shared package keypad_pkg: state encoding (SCAN=2'd0, DEBOUNCE=2'd1, PRESSED=2'd2), COL_RESET=4'b0001, and a priority-encode function (lowest set bit → 2-bit index).
- One sub-module, scan_tick_gen:
  - Parameterised by SCAN_DIV; ports clk, reset_p, tick.
  - Reused later for the display-scan driver on the output side.
- Everything else (synchroniser, FSM, col shifter) stays in keypad_scan_ctrl.

Test Plan (SCAN_DIV=4, DEB_N=3, clean row model responding combinationally to col):
- Reset check: assert reset_p=0 mid-count, release → col=0001, key_valid=0, key_value=0; col sequence 0001,0010,0100,1000,0001 at 4-clk spacing.
- Single press: hold row2/col1 → detection on the tick with col=0010; key_valid=1 and key_value=4'h9 two ticks later. Release → key_valid=0 after 3 ticks of row_s=0, and key_value stays 9.
- Bounce: press row3/col3, drop it for one tick during DEBOUNCE → back to SCAN with key_valid=0. Hold stable afterwards → key_value=4'hF.
- Release bounce: in PRESSED, drive row=0 for 2 ticks, then 1 for 1 tick, then 0 for 3 ticks → key_valid stays 1 until the 3rd consecutive zero tick.
- Multi-key: row0 and row2 pressed in col0 → key_value=4'h0. Add a key in col3 while PRESSED → key_value stays 0 and key_valid stays 1.
- Reset mid-press: assert reset_p=0 while PRESSED → key_valid=0 and col=0001 immediately (asynchronous). Key still held after reset release → re-detected with key_valid high after the normal DEB_N debounce.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg -- shared definitions for the keypad scanner.
//   kp_state_e : scanner FSM state encoding
//   COL_RESET  : column drive after reset
//   penc4()    : lowest set bit of a 4-bit vector -> 2-bit index
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } kp_state_e;

    localparam logic [3:0] COL_RESET = 4'b0001;

    // Lowest set bit wins; an all-zero input encodes as 0.
    function automatic logic [1:0] penc4(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen -- free-running divider producing a one-clock tick.
//   clk     : system clock
//   reset_p : asynchronous active-low reset, clears the counter
//   tick    : high for one clk when the counter sits at SCAN_DIV-1
module scan_tick_gen #(
    parameter int SCAN_DIV = 131072
) (
    input  logic clk,
    input  logic reset_p,
    output logic tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge reset_p) begin
        if (!reset_p)  cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl -- 4x4 matrix keypad scanner with debounce and encoder.
//   clk       : system clock
//   reset_p   : asynchronous active-low reset
//   row       : raw row lines, active-high, asynchronous to clk
//   col       : one-hot column drive, active-high
//   key_value : encoded key, row_idx*4 + col_idx; changes only as key_valid rises
//   key_valid : debounced level, high for the whole press
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 131072,
    parameter int DEB_N    = 8
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_value,
    output logic       key_valid
);

    localparam logic [7:0] DEB_CMP = 8'(DEB_N);

    logic       tick;
    logic [3:0] row_m, row_s;

    kp_state_e  state, state_d;
    logic [3:0] col_d;
    logic [3:0] row_ref, row_ref_d;
    logic [1:0] row_idx, row_idx_d;
    logic [1:0] col_idx, col_idx_d;
    logic [7:0] deb_cnt, deb_cnt_d;
    logic [3:0] key_value_d;
    logic       key_valid_d;

    logic [3:0] col_rot;
    logic [7:0] deb_inc;

    scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk    (clk),
        .reset_p(reset_p),
        .tick   (tick)
    );

    // Two-flop synchroniser; nothing downstream looks at raw row.
    always_ff @(posedge clk or negedge reset_p) begin
        if (!reset_p) begin
            row_m <= '0;
            row_s <= '0;
        end else begin
            row_m <= row;
            row_s <= row_m;
        end
    end

    assign col_rot = {col[2:0], col[3]};
    assign deb_inc = deb_cnt + 8'd1;

    always_ff @(posedge clk or negedge reset_p) begin
        if (!reset_p) begin
            state     <= SCAN;
            col       <= COL_RESET;
            row_ref   <= '0;
            row_idx   <= '0;
            col_idx   <= '0;
            deb_cnt   <= '0;
            key_value <= '0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_d;
            col       <= col_d;
            row_ref   <= row_ref_d;
            row_idx   <= row_idx_d;
            col_idx   <= col_idx_d;
            deb_cnt   <= deb_cnt_d;
            key_value <= key_value_d;
            key_valid <= key_valid_d;
        end
    end

    always_comb begin
        state_d     = state;
        col_d       = col;
        row_ref_d   = row_ref;
        row_idx_d   = row_idx;
        col_idx_d   = col_idx;
        deb_cnt_d   = deb_cnt;
        key_value_d = key_value;
        key_valid_d = key_valid;

        if (tick) begin
            case (state)
                SCAN: begin
                    if (row_s != 4'd0) begin
                        // Column stays put so the same key is re-sampled.
                        col_idx_d = penc4(col);
                        row_idx_d = penc4(row_s);
                        row_ref_d = row_s;
                        deb_cnt_d = 8'd1;
                        state_d   = DEBOUNCE;
                    end else begin
                        col_d = col_rot;
                    end
                end
                DEBOUNCE: begin
                    // Any change of the whole row pattern aborts the candidate.
                    if (row_s == row_ref) begin
                        if (deb_inc == DEB_CMP) begin
                            key_value_d = {row_idx, col_idx};
                            key_valid_d = 1'b1;
                            deb_cnt_d   = 8'd0;
                            state_d     = PRESSED;
                        end else begin
                            deb_cnt_d = deb_inc;
                        end
                    end else begin
                        state_d = SCAN;
                        col_d   = col_rot;
                    end
                end
                PRESSED: begin
                    // Release needs DEB_N consecutive empty ticks.
                    if (row_s == 4'd0) begin
                        if (deb_inc == DEB_CMP) begin
                            key_valid_d = 1'b0;
                            deb_cnt_d   = 8'd0;
                            state_d     = SCAN;
                            col_d       = col_rot;
                        end else begin
                            deb_cnt_d = deb_inc;
                        end
                    end else begin
                        deb_cnt_d = 8'd0;
                    end
                end
                default: begin
                    state_d   = SCAN;
                    col_d     = COL_RESET;
                    deb_cnt_d = 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl -- scoreboard bench for keypad_scan_ctrl.
// A keypad model drives row from the DUT column. A tick-level reference
// model predicts the column and the key_valid/key_value transitions; the
// predicted transitions are queued and a negedge monitor pops them.
module tb_keypad_scan_ctrl;

    localparam int SD = 4;
    localparam int DN = 3;

    logic       clk = 1'b0;
    logic       reset_p = 1'b0;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_value;
    logic       key_valid;

    always #5 clk = ~clk;

    keypad_scan_ctrl #(.SCAN_DIV(SD), .DEB_N(DN)) dut (
        .clk      (clk),
        .reset_p  (reset_p),
        .row      (row),
        .col      (col),
        .key_value(key_value),
        .key_valid(key_valid)
    );

    // Pressed keys, bit index = row*4 + col.
    logic [15:0] keys = 16'h0;

    always_comb begin
        row = 4'h0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && col[c]) row[r] = 1'b1;
    end

    typedef struct {
        logic       v;
        logic [3:0] val;
    } ev_t;

    ev_t expq[$];
    int  tests = 0;
    int  fails = 0;

    // ---------------- reference model (one call per scan tick) -------------
    int         m_mode;   // 0 idle scanning, 1 confirming candidate, 2 key held
    int         m_c;      // column currently driven
    logic [3:0] m_ref;
    int         m_key;
    int         m_cnt;
    logic       m_valid;
    logic [3:0] m_value;

    function automatic logic [3:0] rows_in_col(input int c);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = keys[i*4+c];
        return r;
    endfunction

    function automatic int lowbit(input logic [3:0] v);
        int b;
        b = 0;
        for (int i = 3; i >= 0; i--) if (v[i]) b = i;
        return b;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_c = 0; m_ref = 4'h0; m_key = 0; m_cnt = 0;
        m_valid = 1'b0; m_value = 4'h0;
    endtask

    task automatic push_ev();
        ev_t e;
        e.v = m_valid;
        e.val = m_value;
        expq.push_back(e);
    endtask

    task automatic model_step();
        logic [3:0] r;
        r = rows_in_col(m_c);
        if (m_mode == 0) begin
            if (r != 0) begin
                m_ref = r; m_key = lowbit(r) * 4 + m_c; m_cnt = 1; m_mode = 1;
            end else begin
                m_c = (m_c + 1) % 4;
            end
        end else if (m_mode == 1) begin
            if (r == m_ref) begin
                m_cnt++;
                if (m_cnt == DN) begin
                    m_value = 4'(m_key); m_valid = 1'b1; m_cnt = 0; m_mode = 2;
                    push_ev();
                end
            end else begin
                m_mode = 0; m_c = (m_c + 1) % 4;
            end
        end else begin
            if (r == 0) begin
                m_cnt++;
                if (m_cnt == DN) begin
                    m_valid = 1'b0; m_cnt = 0; m_mode = 0; m_c = (m_c + 1) % 4;
                    push_ev();
                end
            end else begin
                m_cnt = 0;
            end
        end
    endtask

    // ---------------- checking helpers ---------------------------------------
    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Run n scan ticks; the model steps on each tick edge, column checked after.
    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (SD) @(posedge clk);
            model_step();
            @(negedge clk);
            chk("col", col, 4'(1 << m_c));
        end
    endtask

    task automatic wait_mode(input int target, input int bound);
        int k;
        k = 0;
        while (m_mode != target && k < bound) begin
            run_ticks(1);
            k++;
        end
        tests++;
        if (m_mode != target) begin
            fails++;
            $display("FAIL wait_mode: model mode %0d, wanted %0d within %0d ticks", m_mode, target, bound);
        end
    endtask

    // Asynchronous reset landing mid-cycle, outputs checked before any edge.
    task automatic async_reset(input string nm);
        @(posedge clk);
        #2 reset_p = 1'b0;
        #1;
        chk({nm, "_col"}, col, 4'b0001);
        chk({nm, "_valid"}, {3'b0, key_valid}, 4'h0);
        chk({nm, "_value"}, key_value, 4'h0);
        expq.delete();
        model_reset();
        keys = keys;
        repeat (2) @(negedge clk);
        reset_p = 1'b1;
    endtask

    // ---------------- monitor -------------------------------------------------
    logic       prev_v = 1'b0;
    logic [3:0] prev_val = 4'h0;
    ev_t        mon_e;

    always @(negedge clk) begin
        if (!reset_p) begin
            prev_v = 1'b0;
            prev_val = 4'h0;
        end else begin
            if (key_valid !== prev_v) begin
                tests++;
                if (expq.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_edge: key_valid=%b key_value=%h, no edge predicted at %0t",
                             key_valid, key_value, $time);
                end else begin
                    mon_e = expq.pop_front();
                    if (mon_e.v !== key_valid || mon_e.val !== key_value) begin
                        fails++;
                        $display("FAIL key_edge: got valid=%b value=%h, expected valid=%b value=%h at %0t",
                                 key_valid, key_value, mon_e.v, mon_e.val, $time);
                    end
                end
            end
            if (key_valid && prev_v) begin
                tests++;
                if (key_value !== prev_val) begin
                    fails++;
                    $display("FAIL value_stable: key_value %h, was %h while valid at %0t",
                             key_value, prev_val, $time);
                end
            end
            prev_v = key_valid;
            prev_val = key_value;
        end
    end

    // ---------------- stimulus -----------------------------------------------
    initial begin
        int sel;
        int hold;

        model_reset();
        reset_p = 1'b0;
        repeat (3) @(negedge clk);
        reset_p = 1'b1;
        repeat (6) @(posedge clk);

        // Reset in the middle of a tick period, then the idle column walk.
        async_reset("reset");
        run_ticks(5);

        // Single key, row2/col1 -> 9.
        keys = 16'(1) << 9;
        run_ticks(8);
        chk("single_valid", {3'b0, key_valid}, 4'h1);
        chk("single_value", key_value, 4'h9);
        keys = 16'h0;
        run_ticks(2);
        chk("release_hold", {3'b0, key_valid}, 4'h1);
        run_ticks(1);
        chk("release_valid", {3'b0, key_valid}, 4'h0);
        chk("release_value", key_value, 4'h9);

        // Bounce during debounce on row3/col3.
        keys = 16'(1) << 15;
        wait_mode(1, 8);
        keys = 16'h0;
        run_ticks(1);
        chk("bounce_valid", {3'b0, key_valid}, 4'h0);
        keys = 16'(1) << 15;
        run_ticks(10);
        chk("bounce_value", key_value, 4'hF);
        chk("bounce_held", {3'b0, key_valid}, 4'h1);

        // Release bounce: 0,0,1,0,0,0.
        keys = 16'h0;
        run_ticks(2);
        keys = 16'(1) << 15;
        run_ticks(1);
        keys = 16'h0;
        run_ticks(2);
        chk("relbounce_hold", {3'b0, key_valid}, 4'h1);
        run_ticks(1);
        chk("relbounce_drop", {3'b0, key_valid}, 4'h0);

        // Two keys in column 0 (rows 0 and 2), then a key in column 3.
        keys = (16'(1) << 0) | (16'(1) << 8);
        run_ticks(8);
        chk("multi_value", key_value, 4'h0);
        chk("multi_valid", {3'b0, key_valid}, 4'h1);
        keys = keys | (16'(1) << 3);
        run_ticks(4);
        chk("other_col_value", key_value, 4'h0);
        chk("other_col_valid", {3'b0, key_valid}, 4'h1);

        // Reset while held; the key is re-detected after a full debounce.
        async_reset("midpress");
        run_ticks(DN - 1);
        chk("redetect_early", {3'b0, key_valid}, 4'h0);
        run_ticks(1);
        chk("redetect_valid", {3'b0, key_valid}, 4'h1);
        chk("redetect_value", key_value, 4'h0);
        keys = 16'h0;
        run_ticks(DN + 1);

        // Random key patterns held for random tick counts.
        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: keys = 16'h0;
                1: keys = 16'(1) << $urandom_range(0, 15);
                2: keys = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
                default: keys = keys ^ (16'(1) << $urandom_range(0, 15));
            endcase
            hold = $urandom_range(1, 8);
            run_ticks(hold);
        end
        keys = 16'h0;
        run_ticks(DN + 4);

        tests++;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL queue_drain: %0d predicted edges never seen, expected 0", expq.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop in case something wedges the stimulus thread.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
